// File: rtl/multi_channel_clk_divider.sv
// NUM_CH independent clock dividers sharing one clock. Each channel has a
// double-buffered divisor, an enable, a square-wave output and a tick strobe.
module multi_channel_clk_divider #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 26,
  parameter  int DEFAULT_DIV = 50000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  div_q    [NUM_CH];
  logic [CNT_W-1:0]  div_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  eff_div  [NUM_CH];
  logic [NUM_CH-1:0] running_q, running_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              wr_ok;

  // High-phase length: ceil(D/2), so odd divisors spend the extra cycle high.
  function automatic logic [CNT_W:0] half(input logic [CNT_W-1:0] d);
    return ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
  endfunction

  assign wr_ok = wr_en && (32'(wr_ch) < NUM_CH);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eff_div[i]   = pending_q[i] ? shadow_q[i] : div_q[i];
      cnt_d[i]     = cnt_q[i];
      div_d[i]     = div_q[i];
      shadow_d[i]  = shadow_q[i];
      pending_d[i] = pending_q[i];
      running_d[i] = running_q[i];
      clk_out_d[i] = clk_out_q[i];
      tick_d[i]    = tick_q[i];

      if (!en[i]) begin
        cnt_d[i]     = '0;
        running_d[i] = 1'b0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
      end else if (sync || !running_q[i] || (cnt_q[i] == div_q[i] - CNT_W'(1))) begin
        // Period boundary (sync, start or wrap): the shadow takes effect here.
        // A zero divisor lands the channel in the idle state instead.
        div_d[i]     = eff_div[i];
        pending_d[i] = 1'b0;
        cnt_d[i]     = '0;
        running_d[i] = (eff_div[i] != '0);
        clk_out_d[i] = (eff_div[i] != '0);
        tick_d[i]    = (eff_div[i] != '0);
      end else begin
        cnt_d[i]     = cnt_q[i] + CNT_W'(1);
        tick_d[i]    = 1'b0;
        clk_out_d[i] = ({1'b0, cnt_q[i] + CNT_W'(1)} < half(div_q[i]));
      end

      // A write on an apply edge wins over the clear, so it stays pending.
      if (wr_ok && (32'(wr_ch) == i)) begin
        shadow_d[i]  = wr_div;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        div_q[i]    <= CNT_W'(DEFAULT_DIV);
        shadow_q[i] <= CNT_W'(DEFAULT_DIV);
      end
      running_q <= '0;
      pending_q <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        div_q[i]    <= div_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      running_q <= running_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_multi_channel_clk_divider.sv
// Directed, table-driven bench for multi_channel_clk_divider.
// Three channels so that a 2-bit wr_ch can address a non-existent channel.
module tb_multi_channel_clk_divider;

  localparam int N  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en;
  logic          sync;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [CW-1:0] wr_div;
  logic [N-1:0]  clk_out, tick, pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]  en;
    logic          sync;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_div;
    logic [N-1:0]  exp_clk;
    logic [N-1:0]  exp_tick;
    logic [N-1:0]  exp_pend;
  } vec_t;

  vec_t vq[$];

  multi_channel_clk_divider #(.NUM_CH(N), .CNT_W(CW), .DEFAULT_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .clk_out(clk_out), .tick(tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b", name, idx, got, exp);
    end
  endtask

  function automatic void pv(input logic [N-1:0] e, input logic s, input logic w,
                             input logic [1:0] ch, input logic [CW-1:0] d,
                             input logic [N-1:0] c, input logic [N-1:0] t,
                             input logic [N-1:0] p);
    vec_t v;
    v.en = e; v.sync = s; v.wr_en = w; v.wr_ch = ch; v.wr_div = d;
    v.exp_clk = c; v.exp_tick = t; v.exp_pend = p;
    vq.push_back(v);
  endfunction

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic run_vecs(input string tag);
    for (int v = 0; v < vq.size(); v++) begin
      en = vq[v].en; sync = vq[v].sync; wr_en = vq[v].wr_en;
      wr_ch = vq[v].wr_ch; wr_div = vq[v].wr_div;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_clk"}, v, clk_out, vq[v].exp_clk);
      chk({tag, "_tick"}, v, tick, vq[v].exp_tick);
      chk({tag, "_pend"}, v, pending, vq[v].exp_pend);
    end
    vq.delete();
    sync = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (2) @(negedge clk);
    chk("rst_clk", 0, clk_out, '0);
    chk("rst_tick", 0, tick, '0);
    chk("rst_pend", 0, pending, '0);
    rst_n = 1'b1;
  endtask

  function automatic logic [N-1:0] b0(input bit x);
    return x ? 3'b001 : 3'b000;
  endfunction

  function automatic logic [N-1:0] b1(input bit x);
    return x ? 3'b010 : 3'b000;
  endfunction

  initial begin
    do_reset();

    // Default divisor 10 on ch0, preceded by a write to absent channel 3.
    pv(3'b000, 0, 1, 2'd3, 8'd3, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 25; k++)
      pv(3'b001, 0, 0, 0, 0, b0(k % 10 < 5), b0(k % 10 == 0), 3'b000);
    run_vecs("def10");

    // ch1 programmed to 7 while idle, then enabled.
    do_reset();
    pv(3'b000, 0, 1, 2'd1, 8'd7, 3'b000, 3'b000, 3'b010);
    for (int k = 0; k < 16; k++)
      pv(3'b010, 0, 0, 0, 0, b1(k % 7 < 4), b1(k % 7 == 0), 3'b000);
    run_vecs("div7");

    // Shrink 10 -> 4 mid-period: old period completes first.
    do_reset();
    for (int k = 0; k < 10; k++)
      pv(3'b001, 0, k == 3, 2'd0, 8'd4, b0(k % 10 < 5), b0(k % 10 == 0), b0(k >= 3));
    for (int j = 0; j < 12; j++)
      pv(3'b001, 0, 0, 0, 0, b0(j % 4 < 2), b0(j % 4 == 0), 3'b000);
    run_vecs("shrink");

    // ch0 D=6, ch1 D=9, sync mid-period re-aligns both.
    do_reset();
    pv(3'b000, 0, 1, 2'd0, 8'd6, 3'b000, 3'b000, 3'b001);
    pv(3'b000, 0, 1, 2'd1, 8'd9, 3'b000, 3'b000, 3'b011);
    for (int k = 0; k < 5; k++)
      pv(3'b011, 0, 0, 0, 0, b0(k % 6 < 3) | b1(k % 9 < 5),
         b0(k % 6 == 0) | b1(k % 9 == 0), 3'b000);
    for (int j = 0; j < 21; j++)
      pv(3'b011, j == 0, 0, 0, 0, b0(j % 6 < 3) | b1(j % 9 < 5),
         b0(j % 6 == 0) | b1(j % 9 == 0), 3'b000);
    run_vecs("sync");

    // ch2 D=1 holds both outputs high; then D=0 written on a wrap edge idles it.
    do_reset();
    pv(3'b000, 0, 1, 2'd2, 8'd1, 3'b000, 3'b000, 3'b100);
    for (int k = 0; k < 5; k++)
      pv(3'b100, 0, 0, 0, 0, 3'b100, 3'b100, 3'b000);
    pv(3'b100, 0, 1, 2'd2, 8'd0, 3'b100, 3'b100, 3'b100);
    for (int k = 0; k < 4; k++)
      pv(3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    run_vecs("d1d0");

    // Write on the wrap edge: shadow 5 applies, new 4 stays pending.
    do_reset();
    for (int k = 0; k < 10; k++)
      pv(3'b001, 0, k == 3, 2'd0, 8'd5, b0(k % 10 < 5), b0(k % 10 == 0), b0(k >= 3));
    pv(3'b001, 0, 1, 2'd0, 8'd4, 3'b001, 3'b001, 3'b001);
    for (int j = 1; j < 5; j++)
      pv(3'b001, 0, 0, 0, 0, b0(j < 3), 3'b000, 3'b001);
    for (int j = 0; j < 8; j++)
      pv(3'b001, 0, 0, 0, 0, b0(j % 4 < 2), b0(j % 4 == 0), 3'b000);
    run_vecs("wrapwr");

    // Asynchronous reset mid-period with a pending write.
    do_reset();
    for (int k = 0; k < 4; k++)
      pv(3'b001, 0, k == 2, 2'd0, 8'd4, b0(k % 10 < 5), b0(k % 10 == 0), b0(k >= 2));
    run_vecs("prerst");
    #2 rst_n = 1'b0;
    #1;
    chk("async_clk", 0, clk_out, 3'b000);
    chk("async_pend", 0, pending, 3'b000);
    chk("async_tick", 0, tick, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++)
      pv(3'b001, 0, 0, 0, 0, b0(k % 10 < 5), b0(k % 10 == 0), 3'b000);
    run_vecs("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
